// File: rtl/hs_timeout_monitor.sv
// hs_timeout_monitor
//  Passive multi-channel req/ack handshake observer. Every channel runs its
//  own IDLE/WAIT/REL tracker. For each channel it measures the req->ack
//  latency, flags a timeout when the latency goes past TIMEOUT, and flags an
//  abort when req drops before ack arrives. Timeouts and aborts set a sticky
//  error bit.
//  Optional build macro: HS_MON_SVA_EN adds embedded protocol assertions.
//  With the macro undefined, no assertion code is compiled and the logic is
//  identical.
module hs_timeout_monitor #(
    parameter int CH      = 4,
    parameter int CNT_W   = 8,
    parameter int TIMEOUT = 100
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CH-1:0]       req,
    input  logic [CH-1:0]       ack,
    input  logic                clr_err,
    output logic [CH-1:0]       busy,
    output logic [CH-1:0]       done,
    output logic [CH-1:0]       timeout,
    output logic [CH-1:0]       err_sticky,
    output logic [CH*CNT_W-1:0] lat_o,
    output logic                any_err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_REL  = 2'd2
    } state_t;

    // TIMEOUT <= 2**CNT_W-1 keeps the counter from wrapping before the compare hits
    localparam logic [CNT_W-1:0] TMO_C = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);

    genvar gi;
    generate
        for (gi = 0; gi < CH; gi++) begin : g_ch
            state_t           state_r;
            state_t           state_nxt_s;
            logic [CNT_W-1:0] cnt_r;
            logic [CNT_W-1:0] cnt_nxt_s;
            logic             done_s;
            logic             tmo_s;
            logic             err_set_s;
            logic             lat_upd_s;
            logic [CNT_W-1:0] lat_val_s;
            logic             busy_r;
            logic             done_r;
            logic             tmo_r;
            logic             err_r;
            logic [CNT_W-1:0] lat_r;

            // Next-state and event decode for one channel; WAIT priority is ack > abort > timeout
            always_comb begin
                state_nxt_s = state_r;
                cnt_nxt_s   = cnt_r;
                done_s      = 1'b0;
                tmo_s       = 1'b0;
                err_set_s   = 1'b0;
                lat_upd_s   = 1'b0;
                lat_val_s   = '0;
                case (state_r)
                    ST_IDLE: begin
                        if (req[gi] && ack[gi]) begin
                            done_s      = 1'b1;
                            lat_upd_s   = 1'b1;
                            lat_val_s   = '0;
                            cnt_nxt_s   = '0;
                            state_nxt_s = ST_REL;
                        end else if (req[gi]) begin
                            cnt_nxt_s   = ONE_C;
                            state_nxt_s = ST_WAIT;
                        end else begin
                            cnt_nxt_s   = '0;
                            state_nxt_s = ST_IDLE;
                        end
                    end
                    ST_WAIT: begin
                        if (ack[gi]) begin
                            done_s      = 1'b1;
                            lat_upd_s   = 1'b1;
                            lat_val_s   = cnt_r;
                            cnt_nxt_s   = '0;
                            state_nxt_s = ST_REL;
                        end else if (!req[gi]) begin
                            err_set_s   = 1'b1;
                            cnt_nxt_s   = '0;
                            state_nxt_s = ST_IDLE;
                        end else if (cnt_r == TMO_C) begin
                            tmo_s       = 1'b1;
                            err_set_s   = 1'b1;
                            cnt_nxt_s   = '0;
                            state_nxt_s = ST_REL;
                        end else begin
                            cnt_nxt_s   = cnt_r + ONE_C;
                            state_nxt_s = ST_WAIT;
                        end
                    end
                    ST_REL: begin
                        if (!req[gi]) begin
                            state_nxt_s = ST_IDLE;
                        end else begin
                            state_nxt_s = ST_REL;
                        end
                    end
                    default: begin
                        cnt_nxt_s   = '0;
                        state_nxt_s = ST_IDLE;
                    end
                endcase
            end

            // Channel state, counter and registered status outputs
            always_ff @(posedge clk) begin
                if (rst) begin
                    state_r <= ST_IDLE;
                    cnt_r   <= '0;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                    tmo_r   <= 1'b0;
                    err_r   <= 1'b0;
                    lat_r   <= '0;
                end else begin
                    state_r <= state_nxt_s;
                    cnt_r   <= cnt_nxt_s;
                    busy_r  <= (state_nxt_s != ST_IDLE);
                    done_r  <= done_s;
                    tmo_r   <= tmo_s;
                    if (err_set_s) begin
                        err_r <= 1'b1;
                    end else if (clr_err) begin
                        err_r <= 1'b0;
                    end else begin
                        err_r <= err_r;
                    end
                    if (lat_upd_s) begin
                        lat_r <= lat_val_s;
                    end else begin
                        lat_r <= lat_r;
                    end
                end
            end

            assign busy[gi]                   = busy_r;
            assign done[gi]                   = done_r;
            assign timeout[gi]                = tmo_r;
            assign err_sticky[gi]             = err_r;
            assign lat_o[gi*CNT_W +: CNT_W]   = lat_r;
        end
    endgenerate

    assign any_err = |err_sticky;

`ifdef HS_MON_SVA_EN
    clocking cb_mon @(posedge clk);
    endclocking
    default clocking cb_mon;
    default disable iff (rst);

    for (genvar ai = 0; ai < CH; ai++) begin : g_sva
        a_ack_req: assert property (ack[ai] |-> req[ai])
            $info("a_ack_req pass ch%0d @%0t", ai, $time);
            else $error("a_ack_req: ack without req on ch%0d @%0t", ai, $time);
        a_req_hold: assert property (req[ai] && !ack[ai] |=> req[ai])
            $info("a_req_hold pass ch%0d @%0t", ai, $time);
            else $error("a_req_hold: req aborted on ch%0d @%0t", ai, $time);
        a_no_tmo: assert property (!timeout[ai])
            $info("a_no_tmo pass ch%0d @%0t", ai, $time);
            else $error("a_no_tmo: timeout on ch%0d @%0t", ai, $time);
        a_done_1cy: assert property (done[ai] |=> !done[ai])
            $info("a_done_1cy pass ch%0d @%0t", ai, $time);
            else $error("a_done_1cy: done longer than one cycle on ch%0d @%0t", ai, $time);
    end
`endif

endmodule
